// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_pkg
// Brief    : Shared types and byte-lane constants for the core load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10,
        LSU_RSVD = 2'b11
    } lsu_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [3:0] c_be_none    = 4'b0000;
    localparam logic [3:0] c_be_byte0   = 4'b0001;
    localparam logic [3:0] c_be_half_lo = 4'b0011;
    localparam logic [3:0] c_be_half_hi = 4'b1100;
    localparam logic [3:0] c_be_word    = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/mips_cpu_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_lsu_align
// Brief    : Little-endian lane steering for stores and extraction/extension
//            for loads; purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_lsu_align
    import mips_cpu_pkg::*;
(
    input  lsu_size_t   i_req_size,
    input  logic [1:0]  i_req_offset,
    input  logic [31:0] i_req_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misalign,
    input  lsu_size_t   i_ld_size,
    input  logic [1:0]  i_ld_offset,
    input  logic        i_ld_signed,
    input  logic [31:0] i_readdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be       = c_be_none;
        o_wdata    = i_req_wdata;
        o_misalign = 1'b0;
        case (i_req_size)
            LSU_BYTE: begin
                o_be    = c_be_byte0 << i_req_offset;
                o_wdata = {4{i_req_wdata[7:0]}};
            end
            LSU_HALF: begin
                o_be       = i_req_offset[1] ? c_be_half_hi : c_be_half_lo;
                o_wdata    = {2{i_req_wdata[15:0]}};
                o_misalign = i_req_offset[0];
            end
            LSU_WORD: begin
                o_be       = c_be_word;
                o_misalign = |i_req_offset;
            end
            default: o_misalign = 1'b1;
        endcase
    end

    assign w_byte = i_readdata[{i_ld_offset, 3'b000} +: 8];
    assign w_half = i_readdata[{i_ld_offset[1], 4'b0000} +: 16];

    always_comb begin
        o_load_data = i_readdata;
        case (i_ld_size)
            LSU_BYTE: o_load_data = {{24{i_ld_signed & w_byte[7]}}, w_byte};
            LSU_HALF: o_load_data = {{16{i_ld_signed & w_half[15]}}, w_half};
            default:  o_load_data = i_readdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_lsu
// Brief    : Load/store unit bridging the multicycle core to an Avalon-MM
//            master; one byte/half/word access per request.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_lsu
    import mips_cpu_pkg::*;
#(
    parameter int MAX_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    lsu_state_t  r_state;
    lsu_state_t  w_next_state;
    logic        r_write;
    lsu_size_t   r_size;
    logic        r_signed;
    logic [1:0]  r_offset;
    logic [31:0] r_address;
    logic [31:0] r_writedata;
    logic [3:0]  r_byteenable;
    logic [CW-1:0] r_wait_cnt;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_misalign;
    logic [31:0] w_load_data;
    logic        w_timeout;

    mips_cpu_lsu_align u_align (
        .i_req_size   (lsu_size_t'(req_size)),
        .i_req_offset (req_addr[1:0]),
        .i_req_wdata  (req_wdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misalign   (w_misalign),
        .i_ld_size    (r_size),
        .i_ld_offset  (r_offset),
        .i_ld_signed  (r_signed),
        .i_readdata   (readdata),
        .o_load_data  (w_load_data)
    );

    // Abort only while the slave is still stalling once the budget is used up.
    assign w_timeout = (MAX_WAIT > 0) && waitrequest && (r_wait_cnt == CW'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next_state = w_misalign ? DONE : BUS;
                end
            end
            BUS: begin
                if (!waitrequest || w_timeout) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write      <= 1'b0;
            r_size       <= LSU_BYTE;
            r_signed     <= 1'b0;
            r_offset     <= 2'b00;
            r_address    <= 32'h0;
            r_writedata  <= 32'h0;
            r_byteenable <= c_be_none;
            r_wait_cnt   <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write      <= req_write;
                        r_size       <= lsu_size_t'(req_size);
                        r_signed     <= req_signed;
                        r_offset     <= req_addr[1:0];
                        r_address    <= {req_addr[31:2], 2'b00};
                        r_writedata  <= w_wdata;
                        r_byteenable <= w_be;
                        r_wait_cnt   <= '0;
                        r_rsp_err    <= w_misalign;
                        r_rsp_rdata  <= 32'h0;
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        r_rsp_rdata <= r_write ? 32'h0 : w_load_data;
                        r_rsp_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_rdata <= 32'h0;
                        r_rsp_err   <= 1'b1;
                    end else if (r_wait_cnt != {CW{1'b1}}) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == DONE);
    assign rsp_err    = r_rsp_err;
    assign rsp_rdata  = r_rsp_rdata;
    assign read       = (r_state == BUS) && !r_write;
    assign write      = (r_state == BUS) && r_write;
    assign address    = r_address;
    assign writedata  = r_writedata;
    assign byteenable = r_byteenable;

endmodule
`default_nettype wire
